// File: rtl/sd_emmc_fifo_filler_pkg.sv
// Shared constants for the SD/eMMC data buffer. These sit alongside the
// existing sd_defines: the block geometry and direction encoding.
package sd_emmc_fifo_filler_pkg;

  localparam int DW        = 32;
  localparam int DEPTH     = 128;
  localparam int AW        = $clog2(DEPTH);
  localparam int BLK_WORDS = DEPTH;

  // Transfer direction as driven by the DMA.
  typedef enum logic {
    DIR_WRITE = 1'b0,  // host -> card
    DIR_READ  = 1'b1   // card -> host
  } dir_e;

  // Count value that means "full" (count is one bit wider than a pointer).
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Rising-edge detect given the current level and its registered copy.
  function automatic logic rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/sd_emmc_fifo_filler_sync_fifo.sv
// Single-clock FIFO: RAM, pointers, occupancy count, registered full/empty
// and sticky overflow/underflow. The head word is read combinationally so
// the parent can register it for show-ahead or on a pop.
module sd_emmc_sync_fifo
  import sd_emmc_fifo_filler_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          push_acc_o,
  output logic          pop_acc_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          ovf_o,
  output logic          udf_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          push_acc, pop_acc;

  // A push into a full FIFO is still legal when a pop frees the slot in the
  // same cycle; a pop from an empty FIFO is never legal, even with a push.
  always_comb begin
    pop_acc  = pop_i & ~empty_q;
    push_acc = push_i & (~full_q | pop_i);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_acc)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d  = count_q + (AW+1)'(push_acc) - (AW+1)'(pop_acc);
    full_d   = (count_d == FULL_CNT);
    empty_d  = (count_d == '0);
    ovf_d    = ovf_q | (push_i & full_q & ~pop_i);
    udf_d    = udf_q | (pop_i & empty_q);
  end

  // Pointer, count and flag registers; reset and clear win over traffic.
  always_ff @(posedge clock) begin
    if (!reset || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array; no reset so it maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (reset && !clr_i && push_acc) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o     = mem_q[rd_ptr_q];
  assign push_acc_o = push_acc;
  assign pop_acc_o  = pop_acc;
  assign count_o    = count_q;
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign ovf_o      = ovf_q;
  assign udf_o      = udf_q;

endmodule

// File: rtl/sd_emmc_fifo_filler.sv
// Block buffer between the SD/eMMC serializer and the DMA/M_AXI engine.
// Direction picks who pushes and who pops; the DMA ready lines are levels,
// so each is edge-detected and a rising edge moves exactly one word.
module sd_emmc_fifo_filler
  import sd_emmc_fifo_filler_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          fifo_rst,
  input  logic          dir,
  input  logic          ser_wr_en,
  input  logic [DW-1:0] ser_wr_data,
  input  logic          ser_rd_en,
  output logic [DW-1:0] ser_rd_data,
  output logic          is_we_en,
  input  logic          fifo_dat_rd_ready,
  output logic [DW-1:0] m_axi_wdata,
  input  logic          fifo_dat_wr_ready,
  input  logic [DW-1:0] m_axi_rdata,
  input  logic          axi_rvalid,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic [AW:0]   fifo_count,
  output logic          overflow,
  output logic          underflow
);

  logic          rd_rdy_q, wr_rdy_q;
  logic          is_we_en_q, is_we_en_d;
  logic [DW-1:0] ser_rd_data_q, ser_rd_data_d;
  logic [DW-1:0] m_axi_wdata_q, m_axi_wdata_d;
  logic          dir_rd;
  logic          push, pop;
  logic [DW-1:0] push_data;
  logic [DW-1:0] head;
  logic          push_acc, pop_acc;

  sd_emmc_sync_fifo u_fifo (
    .clock      (clock),
    .reset      (reset),
    .clr_i      (fifo_rst),
    .push_i     (push),
    .wdata_i    (push_data),
    .pop_i      (pop),
    .head_o     (head),
    .push_acc_o (push_acc),
    .pop_acc_o  (pop_acc),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .ovf_o      (overflow),
    .udf_o      (underflow)
  );

  // Direction muxing and next values of the output registers. dir is used
  // live every cycle; the strobes of the idle side are simply not selected.
  always_comb begin
    dir_rd = (dir == DIR_READ);
    if (dir_rd) begin
      push      = ser_wr_en;
      push_data = ser_wr_data;
      pop       = rise(fifo_dat_rd_ready, rd_rdy_q);
    end else begin
      push      = rise(fifo_dat_wr_ready, wr_rdy_q) & axi_rvalid;
      push_data = m_axi_rdata;
      pop       = ser_rd_en;
    end
    is_we_en_d    = dir_rd & push_acc;
    ser_rd_data_d = (!dir_rd && pop_acc) ? head : ser_rd_data_q;
    // Show-ahead: follow the head while there is one, hold once drained.
    m_axi_wdata_d = fifo_empty ? m_axi_wdata_q : head;
  end

  // Edge-detect history for the DMA ready levels; only a full reset clears
  // it so a fifo_rst does not fabricate an edge on a level already high.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_rdy_q <= 1'b0;
      wr_rdy_q <= 1'b0;
    end else begin
      rd_rdy_q <= fifo_dat_rd_ready;
      wr_rdy_q <= fifo_dat_wr_ready;
    end
  end

  // Output data and write-strobe registers.
  always_ff @(posedge clock) begin
    if (!reset || fifo_rst) begin
      is_we_en_q    <= 1'b0;
      ser_rd_data_q <= '0;
      m_axi_wdata_q <= '0;
    end else begin
      is_we_en_q    <= is_we_en_d;
      ser_rd_data_q <= ser_rd_data_d;
      m_axi_wdata_q <= m_axi_wdata_d;
    end
  end

  assign is_we_en    = is_we_en_q;
  assign ser_rd_data = ser_rd_data_q;
  assign m_axi_wdata = m_axi_wdata_q;

endmodule
